// File: rtl/nf_10g_tx_frame_gate.sv
// nf_10g_tx_frame_gate: store-and-forward TX gate that releases only fully buffered frames to the 10GE MAC,
// so tvalid never drops inside a frame; frames larger than the buffer are discarded and counted.
module nf_10g_tx_frame_gate #(
  parameter int C_DATA_WIDTH    = 64,
  parameter int C_FIFO_DEPTH    = 512,
  parameter int C_FRM_CNT_WIDTH = 6
) (
  input  logic                      clk156,
  input  logic                      areset_clk156,
  input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                      s_axis_tlast,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [C_DATA_WIDTH-1:0]   m_axis_mac_tdata,
  output logic [C_DATA_WIDTH/8-1:0] m_axis_mac_tkeep,
  output logic                      m_axis_mac_tlast,
  output logic                      m_axis_mac_tuser,
  output logic                      m_axis_mac_tvalid,
  input  logic                      m_axis_mac_tready,
  output logic [31:0]               tx_frames_sent,
  output logic [15:0]               tx_frames_dropped
);
  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int WW = C_DATA_WIDTH + C_DATA_WIDTH/8 + 1;
  typedef enum logic {IDLE, SEND} state_t;
  logic [WW-1:0] ram [C_FIFO_DEPTH];
  logic [AW:0] wr_ptr, commit_ptr, rd_ptr;
  logic [AW-1:0] rd_addr;
  logic [C_FRM_CNT_WIDTH-1:0] frm_cnt, frm_nxt;
  state_t state, state_nxt;
  logic drop, full, drop_now, acc, we, commit, hs, deliver, load;
  logic [WW-1:0] wr_word, rd_word, out_word;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign drop_now = drop | (full & frm_cnt == '0);
  // also stall when the frame counter is saturated so it can never wrap
  assign s_axis_tready = !areset_clk156 & (drop_now | (!full & frm_cnt != '1));
  assign acc = s_axis_tvalid & s_axis_tready;
  assign we = acc & !drop_now;
  assign commit = we & s_axis_tlast;
  assign hs = m_axis_mac_tvalid & m_axis_mac_tready;
  assign deliver = hs & out_word[WW-1];
  assign frm_nxt = frm_cnt + C_FRM_CNT_WIDTH'(commit) - C_FRM_CNT_WIDTH'(deliver);
  assign wr_word = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  assign rd_addr = state == SEND ? rd_ptr[AW-1:0] + 1'b1 : rd_ptr[AW-1:0];
  // a one-beat frame committed while the previous tlast leaves must be forwarded from the write port
  assign rd_word = (we && wr_ptr[AW-1:0] == rd_addr) ? wr_word : ram[rd_addr];
  assign load = state == SEND ? hs : frm_cnt != '0;
  always_ff @(posedge clk156)
    if (we) ram[wr_ptr[AW-1:0]] <= wr_word;
  always_ff @(posedge clk156) begin
    if (areset_clk156) begin
      wr_ptr <= '0;
      commit_ptr <= '0;
      drop <= 1'b0;
      tx_frames_dropped <= '0;
    end else begin
      if (full & frm_cnt == '0) wr_ptr <= commit_ptr;
      else if (we) wr_ptr <= wr_ptr + 1'b1;
      if (commit) commit_ptr <= wr_ptr + 1'b1;
      if (drop_now) drop <= !(acc & s_axis_tlast);
      if (drop_now & acc & s_axis_tlast & tx_frames_dropped != '1) tx_frames_dropped <= tx_frames_dropped + 1'b1;
    end
  end
  always_ff @(posedge clk156)
    state <= areset_clk156 ? IDLE : state_nxt;
  always_comb
    state_nxt = state == IDLE ? (frm_cnt != '0 ? SEND : IDLE) : (deliver ? (frm_nxt != '0 ? SEND : IDLE) : SEND);
  always_comb begin
    m_axis_mac_tvalid = !areset_clk156 && state == SEND;
    m_axis_mac_tlast = m_axis_mac_tvalid && out_word[WW-1];
    m_axis_mac_tkeep = areset_clk156 ? '0 : out_word[WW-2:C_DATA_WIDTH];
    m_axis_mac_tdata = areset_clk156 ? '0 : out_word[C_DATA_WIDTH-1:0];
    m_axis_mac_tuser = 1'b0;
  end
  always_ff @(posedge clk156) begin
    if (areset_clk156) begin
      rd_ptr <= '0;
      frm_cnt <= '0;
      out_word <= '0;
      tx_frames_sent <= '0;
    end else begin
      frm_cnt <= frm_nxt;
      if (load) out_word <= rd_word;
      if (hs) rd_ptr <= rd_ptr + 1'b1;
      if (deliver) tx_frames_sent <= tx_frames_sent + 1'b1;
    end
  end
endmodule

// File: tb/tb_nf_10g_tx_frame_gate.sv
// tb_nf_10g_tx_frame_gate: directed table, corner sequences and random frames checked against a frame-level model.
module tb_nf_10g_tx_frame_gate;
  localparam int DEPTH = 512;
  logic clk = 0, rst = 1;
  logic [63:0] s_tdata = '0;
  logic [7:0] s_tkeep = '0;
  logic s_tlast = 0, s_tvalid = 0, s_tready;
  logic [63:0] m_tdata;
  logic [7:0] m_tkeep;
  logic m_tlast, m_tuser, m_tvalid, m_tready = 0;
  logic [31:0] sent;
  logic [15:0] dropped;
  int vectors = 0, errors = 0, cyc = 0, mac_mode = 3;
  int model_sent = 0, model_drop = 0, stall_cnt = 0, first_valid = -1, last_acc_cyc = 0;
  logic in_frame = 0;
  typedef struct {logic [63:0] d; logic [7:0] k; logic l;} beat_t;
  typedef struct {int len; logic [7:0] lkeep; int gap; int mode; int exp_sent; int exp_drop;} vec_t;
  beat_t exp_q[$];
  vec_t tbl[8];

  nf_10g_tx_frame_gate dut (
    .clk156(clk), .areset_clk156(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_mac_tdata(m_tdata), .m_axis_mac_tkeep(m_tkeep), .m_axis_mac_tlast(m_tlast),
    .m_axis_mac_tuser(m_tuser), .m_axis_mac_tvalid(m_tvalid), .m_axis_mac_tready(m_tready),
    .tx_frames_sent(sent), .tx_frames_dropped(dropped)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // MAC ready patterns: 0 always ready, 1 toggle, 2 random, 3 held off
  initial forever begin
    @(posedge clk);
    #1;
    m_tready = mac_mode == 0 ? 1'b1 : mac_mode == 1 ? !m_tready : mac_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // output monitor: in-order beat scoreboard, no gaps inside a frame, stable output while stalled
  initial begin
    beat_t e, prev;
    logic prev_stall;
    prev_stall = 0;
    prev = '{0, 0, 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 0;
        prev_stall = 0;
      end else begin
        if (prev_stall) chk("hold", {m_tvalid, m_tlast, m_tkeep, m_tdata}, {1'b1, prev.l, prev.k, prev.d});
        else if (in_frame) chk("gap", 80'(m_tvalid), 80'd1);
        if (m_tvalid && first_valid < 0) first_valid = cyc;
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL extra_beat: got data %0h, expected no beat", m_tdata);
          end else begin
            e = exp_q.pop_front();
            chk("beat", {m_tlast, m_tkeep, m_tdata}, {e.l, e.k, e.d});
          end
          in_frame = !m_tlast;
        end
        prev_stall = m_tvalid && !m_tready;
        prev = '{m_tdata, m_tkeep, m_tlast};
      end
    end
  end

  task automatic send_frame(input int len, input logic [7:0] lkeep, input int gap);
    beat_t fr[$];
    beat_t b;
    int w;
    logic a;
    for (int i = 0; i < len; i++) begin
      b.d = {$urandom, $urandom};
      b.l = i == len - 1;
      b.k = b.l ? lkeep : 8'hFF;
      if (gap > 0 && i % gap == gap - 1) begin
        s_tvalid = 0;
        @(posedge clk);
        #1;
      end
      s_tdata = b.d;
      s_tkeep = b.k;
      s_tlast = b.l;
      s_tvalid = 1;
      w = 0;
      do begin
        @(negedge clk);
        a = s_tready;
        if (!a) stall_cnt++;
        else if (b.l) last_acc_cyc = cyc;
        @(posedge clk);
        #1;
        w++;
      end while (!a && w < 4000);
      if (!a) begin
        vectors++;
        errors++;
        $display("FAIL send_timeout: tready 0 for %0d cycles, required 1", w);
        s_tvalid = 0;
        return;
      end
      fr.push_back(b);
    end
    s_tvalid = 0;
    if (len <= DEPTH) begin
      foreach (fr[i]) exp_q.push_back(fr[i]);
      model_sent++;
    end else model_drop++;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || in_frame || m_tvalid) && w < 20000) begin
      @(negedge clk);
      w++;
    end
    chk("drain_left", 80'(exp_q.size()), 80'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, r;
    tbl[0] = '{8, 8'h0F, 0, 0, 1, 0};
    tbl[1] = '{20, 8'hFF, 3, 0, 2, 0};
    tbl[2] = '{10, 8'h01, 0, 1, 3, 0};
    tbl[3] = '{600, 8'hFF, 0, 0, 3, 1};
    tbl[4] = '{4, 8'h3F, 0, 0, 4, 1};
    tbl[5] = '{DEPTH, 8'h7F, 0, 0, 5, 1};
    tbl[6] = '{DEPTH + 1, 8'hFF, 0, 0, 5, 2};
    tbl[7] = '{1, 8'h80, 0, 0, 6, 2};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tready", 80'(s_tready), 80'd0);
    chk("rst_tvalid", 80'(m_tvalid), 80'd0);
    chk("rst_tlast_tuser", {m_tlast, m_tuser}, 80'd0);
    chk("rst_data_keep", {m_tkeep, m_tdata}, 80'd0);
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("post_rst_tready", 80'(s_tready), 80'd1);
    chk("post_rst_counters", {sent, dropped}, 80'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      mac_mode = tbl[i].mode;
      stall_cnt = 0;
      first_valid = -1;
      send_frame(tbl[i].len, tbl[i].lkeep, tbl[i].gap);
      drain();
      chk($sformatf("tbl%0d_sent", i), 80'(sent), 80'(tbl[i].exp_sent));
      chk($sformatf("tbl%0d_dropped", i), 80'(dropped), 80'(tbl[i].exp_drop));
      chk($sformatf("tbl%0d_in_stall", i), 80'(stall_cnt), 80'd0);
      if (i == 0) chk("latency", 80'(first_valid - last_acc_cyc), 80'd2);
      @(posedge clk);
      #1;
    end
    // two committed 250-beat frames behind a stalled MAC, then a third that must wait, not drop
    mac_mode = 3;
    send_frame(250, 8'hFF, 0);
    send_frame(250, 8'h0F, 0);
    fork
      send_frame(20, 8'h03, 0);
      begin
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("full_stall", 80'(s_tready), 80'd0);
        chk("full_no_drop", 80'(dropped), 80'd2);
        chk("full_waiting", 80'(m_tvalid), 80'd1);
        @(posedge clk);
        #1;
        mac_mode = 0;
      end
    join
    drain();
    chk("full_sent", 80'(sent), 80'd9);
    chk("full_dropped", 80'(dropped), 80'd2);
    // reset in the middle of an output frame with another frame queued behind it
    @(posedge clk);
    #1;
    mac_mode = 3;
    send_frame(30, 8'hFF, 0);
    send_frame(10, 8'hFF, 0);
    mac_mode = 0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1;
    @(negedge clk);
    chk("midrst_tvalid", 80'(m_tvalid), 80'd0);
    chk("midrst_tready", 80'(s_tready), 80'd0);
    @(posedge clk);
    #1;
    rst = 0;
    exp_q.delete();
    model_sent = 0;
    model_drop = 0;
    @(negedge clk);
    chk("after_rst_tvalid", 80'(m_tvalid), 80'd0);
    chk("after_rst_counters", {sent, dropped}, 80'd0);
    chk("after_rst_tready", 80'(s_tready), 80'd1);
    @(posedge clk);
    #1;
    send_frame(4, 8'h1F, 0);
    drain();
    chk("after_rst_sent", 80'(sent), 80'd1);
    // random frames, gaps and MAC backpressure, including lengths around the buffer depth
    @(posedge clk);
    #1;
    mac_mode = 2;
    for (int i = 0; i < 25; i++) begin
      r = $urandom_range(0, 9);
      len = r < 2 ? $urandom_range(DEPTH - 3, DEPTH + 3) : r < 5 ? $urandom_range(1, 2) : $urandom_range(3, 40);
      send_frame(len, 8'($urandom_range(1, 255)), $urandom_range(0, 4));
    end
    drain();
    chk("rand_sent", 80'(sent), 80'(model_sent));
    chk("rand_dropped", 80'(dropped), 80'(model_drop));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
